// File: rtl/instr_encoder.sv
// Serializes one Y86-style instruction per handshake into instruction-memory byte writes.
// Two-state FSM (IDLE/EMIT); busy mirrors the state so checkers can observe it directly.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [3:0]  in_ifun,
  input  logic [3:0]  in_rA,
  input  logic [3:0]  in_rB,
  input  logic [63:0] in_valC,
  input  logic        addr_load,
  input  logic [9:0]  addr_init,
  input  logic        err_clr,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic [10:0] next_addr,
  output logic [15:0] instr_count,
  output logic        inv_err,
  output logic        ovf_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      r_state;
  logic [3:0]  r_rA, r_rB, r_len, r_idx;
  logic [63:0] r_valC;
  logic [10:0] r_next_addr;
  logic [15:0] r_instr_count;
  logic        r_mem_we, r_inv_err, r_ovf_err;
  logic [9:0]  r_mem_addr;
  logic [7:0]  r_mem_wdata;

  logic [3:0]  w_len;
  logic [11:0] w_end;
  logic        w_xfer;
  logic [2:0]  w_sh;
  logic [7:0]  w_byte;

  function automatic logic [3:0] len_of(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd0;
    endcase
  endfunction

  // Handshake: a transfer happens on a posedge where in_valid && in_ready; in_ready
  // depends only on state, addr_load and rst, never on in_valid.
  assign in_ready = (r_state == IDLE) && !addr_load && !rst;
  assign w_xfer   = in_valid && in_ready;
  assign w_len    = len_of(in_icode);
  assign w_end    = {1'b0, r_next_addr} + {8'b0, w_len};

  // Byte 0 goes out at acceptance; this selects bytes 1..len-1 from latched fields.
  always_comb begin
    w_sh   = (r_len == 4'd9) ? 3'(4'd8 - r_idx) : 3'(4'd9 - r_idx);
    w_byte = {r_rA, r_rB};
    if (r_len == 4'd9 || (r_len == 4'd10 && r_idx >= 4'd2))
      w_byte = 8'(r_valC >> {w_sh, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rA          <= '0;
      r_rB          <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_valC        <= '0;
      r_next_addr   <= '0;
      r_instr_count <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_inv_err     <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      if (err_clr) begin
        r_inv_err <= 1'b0;
        r_ovf_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_mem_we <= 1'b0;
          if (addr_load) begin
            r_next_addr <= {1'b0, addr_init};
          end else if (w_xfer) begin
            if (w_len == 4'd0) begin
              r_inv_err <= 1'b1;
            end else if (w_end > 12'd1024) begin
              r_ovf_err <= 1'b1;
            end else begin
              r_rA        <= in_rA;
              r_rB        <= in_rB;
              r_valC      <= in_valC;
              r_len       <= w_len;
              r_idx       <= 4'd1;
              r_state     <= EMIT;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_next_addr[9:0];
              r_mem_wdata <= {in_icode, in_ifun};
              r_next_addr <= r_next_addr + 11'd1;
            end
          end
        end
        EMIT: begin
          if (r_idx == r_len) begin
            r_state       <= IDLE;
            r_mem_we      <= 1'b0;
            r_instr_count <= r_instr_count + 16'd1;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_next_addr[9:0];
            r_mem_wdata <= w_byte;
            r_next_addr <= r_next_addr + 11'd1;
            r_idx       <= r_idx + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == EMIT);
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign next_addr   = r_next_addr;
  assign instr_count = r_instr_count;
  assign inv_err     = r_inv_err;
  assign ovf_err     = r_ovf_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: byte layouts, timing, boundaries, errors, reset abort.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC;
  logic        addr_load;
  logic [9:0]  addr_init;
  logic        err_clr;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic [10:0] next_addr;
  logic [15:0] instr_count;
  logic        inv_err, ovf_err;

  int n_cmp = 0;
  int n_err = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .addr_load(addr_load), .addr_init(addr_init),
    .err_clr(err_clr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .next_addr(next_addr),
    .instr_count(instr_count), .inv_err(inv_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction, checks it is accepted, and advances into the first write cycle.
  task automatic send(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    in_valid = 1'b1;
    in_icode = ic;
    in_ifun  = fn;
    in_rA    = ra;
    in_rB    = rb;
    in_valC  = vc;
    #1;
    chk({tag, "_ready"}, in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input int a, input logic [7:0] d);
    chk({tag, "_we"}, mem_we, 1'b1);
    chk({tag, "_addr"}, mem_addr, 64'(a));
    chk({tag, "_data"}, mem_wdata, d);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_rdy_lo"}, in_ready, 1'b0);
    cyc();
  endtask

  task automatic load_addr(input logic [9:0] a);
    addr_load = 1'b1;
    addr_init = a;
    cyc();
    addr_load = 1'b0;
    chk("load_addr", next_addr, 64'(a));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_we_lo"}, mem_we, 1'b0);
    chk({tag, "_busy_lo"}, busy, 1'b0);
    chk({tag, "_ready_hi"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] rm_bytes [10];
    rm_bytes = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_init = '0; err_clr = 1'b0;
    in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0; in_valC = '0;
    cyc();
    chk("rst_ready_lo", in_ready, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_next_addr", next_addr, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_inv", inv_err, 0);
    chk("rst_ovf", ovf_err, 0);
    expect_idle("rst");

    // irmovq at 37
    addr_load = 1'b1;
    addr_init = 10'd37;
    #1;
    chk("load_ready_lo", in_ready, 1'b0);
    cyc();
    addr_load = 1'b0;
    chk("load37", next_addr, 37);
    send("irmovq", 4'h3, 4'h0, 4'hF, 4'h4, 64'h10);
    expect_byte("irm0", 37, 8'h30);
    expect_byte("irm1", 38, 8'hF4);
    for (int i = 0; i < 7; i++) expect_byte("irm_z", 39 + i, 8'h00);
    expect_byte("irm9", 46, 8'h10);
    expect_idle("irm_end");
    chk("irm_next", next_addr, 47);
    chk("irm_count", instr_count, 1);

    // halt, nop, ret back to back from 0
    load_addr(10'd0);
    send("halt", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
    expect_byte("halt", 0, 8'h00);
    expect_idle("halt_end");
    send("nop", 4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    expect_byte("nop", 1, 8'h10);
    expect_idle("nop_end");
    send("ret", 4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
    expect_byte("ret", 2, 8'h90);
    expect_idle("ret_end");
    chk("short_count", instr_count, 4);
    chk("short_next", next_addr, 3);

    // rmmovq ending exactly at 1023; addr_load mid-emit must be ignored
    load_addr(10'd1014);
    send("rmmovq", 4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    expect_byte("rm0", 1014, rm_bytes[0]);
    addr_load = 1'b1;
    addr_init = 10'd5;
    for (int i = 1; i < 10; i++) expect_byte("rm", 1014 + i, rm_bytes[i]);
    addr_load = 1'b0;
    #1;
    expect_idle("rm_end");
    chk("rm_next", next_addr, 1024);
    chk("rm_count", instr_count, 5);
    send("full_nop", 4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    expect_idle("full_nop");
    chk("full_ovf", ovf_err, 1);
    chk("full_next", next_addr, 1024);
    err_clr = 1'b1;
    send("ovf_vs_clr", 4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    chk("ovf_wins_clr", ovf_err, 1);
    cyc();
    err_clr = 1'b0;
    chk("ovf_cleared", ovf_err, 0);
    chk("ovf_count", instr_count, 5);

    // invalid icode
    load_addr(10'd0);
    send("inv", 4'hD, 4'h0, 4'h0, 4'h0, 64'h0);
    expect_idle("inv");
    chk("inv_set", inv_err, 1);
    chk("inv_next", next_addr, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("inv_cleared", inv_err, 0);

    // jxx, aborted by reset during the 4th write
    send("jxx", 4'h7, 4'h1, 4'h0, 4'h0, 64'h0102030405060708);
    expect_byte("jxx0", 0, 8'h71);
    expect_byte("jxx1", 1, 8'h01);
    expect_byte("jxx2", 2, 8'h02);
    chk("jxx3_we", mem_we, 1);
    chk("jxx3_addr", mem_addr, 3);
    chk("jxx3_data", mem_wdata, 8'h03);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    expect_idle("abort");
    chk("abort_next", next_addr, 0);
    chk("abort_count", instr_count, 0);
    cyc();
    cyc();
    chk("abort_quiet", mem_we, 0);

    // addr_load beats in_valid, instruction taken next cycle
    addr_load = 1'b1;
    addr_init = 10'd100;
    in_valid = 1'b1;
    in_icode = 4'h1; in_ifun = 4'h0;
    #1;
    chk("prio_ready_lo", in_ready, 1'b0);
    cyc();
    addr_load = 1'b0;
    chk("prio_next", next_addr, 100);
    chk("prio_no_write", mem_we, 0);
    send("prio_nop", 4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    expect_byte("prio_nop", 100, 8'h10);
    expect_idle("prio_end");
    chk("prio_count", instr_count, 1);
    chk("prio_next2", next_addr, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
